pwm_downcounter: RTL and testbench



---
 rtl/pwm_downcounter_if.sv | 11 +
 rtl/pwm_downcounter.sv | 51 +++++
 tb/tb_pwm_downcounter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pwm_downcounter_if.sv
// Duty request and timing outputs shared between the PWM parent and pwm_downcounter.
interface pwm_downcounter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] duty_cycle;
    logic             zero;
    logic             pwm_out;

    modport master (output duty_cycle, input zero, input pwm_out);
    modport slave  (input duty_cycle, output zero, output pwm_out);
endinterface

// File: rtl/pwm_downcounter.sv
// Reloadable tick downcounter plus free-running counter-compare PWM modulator.
// Define PWM_DUTY_SHADOW_EN to latch the duty once per PWM period (glitch-free periods).
module pwm_downcounter #(
    parameter int unsigned WIDTH  = 8,
    parameter int          PERIOD = 392
) (
    input  logic           clk,
    input  logic           reset,
    pwm_downcounter_if.slave bus
);
    localparam int unsigned DW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [DW-1:0] RELOAD = DW'(PERIOD - 1);

    if (PERIOD < 1) begin : g_bad_period
        $error("pwm_downcounter: PERIOD must be at least 1");
    end

    logic [DW-1:0]    cnt_d;
    logic [WIDTH-1:0] cnt_p;
    logic [WIDTH-1:0] duty_eff;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_d <= RELOAD;
            cnt_p <= '0;
        end else begin
            cnt_d <= (cnt_d == '0) ? RELOAD : cnt_d - DW'(1);
            cnt_p <= cnt_p + WIDTH'(1);
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [WIDTH-1:0] duty_shadow;

    // Load on the last count so the new value governs the whole next period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            duty_shadow <= '0;
        end else if (cnt_p == '1) begin
            duty_shadow <= bus.duty_cycle;
        end
    end

    assign duty_eff = duty_shadow;
`else
    assign duty_eff = bus.duty_cycle;
`endif

    assign bus.zero    = (cnt_d == '0);
    assign bus.pwm_out = (cnt_p < duty_eff);
endmodule

// File: tb/tb_pwm_downcounter.sv
// Directed bench for pwm_downcounter: PERIOD=4 and PERIOD=1 instances, WIDTH=8.
module tb_pwm_downcounter;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

`ifdef PWM_DUTY_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    pwm_downcounter_if #(.WIDTH(8)) bus4 ();
    pwm_downcounter_if #(.WIDTH(8)) bus1 ();

    pwm_downcounter #(.WIDTH(8), .PERIOD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    pwm_downcounter #(.WIDTH(8), .PERIOD(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Called at a negedge where cnt_p == 0; returns at the next such negedge.
    task automatic run_period(input int change_at, input logic [7:0] new_duty,
                              output int highs, output int first_low, output int late_high);
        highs = 0;
        first_low = 256;
        late_high = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == change_at) bus4.duty_cycle = new_duty;
            #1;
            if (bus4.pwm_out) begin
                highs++;
                if (first_low != 256) late_high++;
            end else if (first_low == 256) begin
                first_low = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus4.duty_cycle = '0;
        bus1.duty_cycle = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus4.zero !== 1'b0) begin fails++; $display("FAIL reset_zero got %b want 0", bus4.zero); end
        tests++;
        if (bus4.pwm_out !== 1'b0) begin fails++; $display("FAIL reset_pwm got %b want 0", bus4.pwm_out); end
        tests++;
        if (dut.cnt_p !== 8'd0) begin fails++; $display("FAIL reset_cnt_p got %0d want 0", dut.cnt_p); end
        tests++;
        if (dut.cnt_d !== 2'd3) begin fails++; $display("FAIL reset_cnt_d got %0d want 3", dut.cnt_d); end
        tests++;
        if (bus1.zero !== 1'b1) begin fails++; $display("FAIL reset_zero_p1 got %b want 1", bus1.zero); end
    endtask

    task automatic test_tick();
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tests++;
            if (bus4.zero !== ((k % 4) == 3)) begin
                fails++; $display("FAIL tick_k%0d got %b want %b", k, bus4.zero, (k % 4) == 3);
            end
            tests++;
            if (bus1.zero !== 1'b1) begin fails++; $display("FAIL tick_p1_k%0d got %b want 1", k, bus1.zero); end
            tests++;
            if (dut.cnt_p !== 8'(k)) begin fails++; $display("FAIL tick_cnt_p_k%0d got %0d want %0d", k, dut.cnt_p, k); end
        end
    endtask

    task automatic test_duty(input logic [7:0] duty);
        int h, fl, lh;
        bus4.duty_cycle = duty;
        do_reset();
        tests++;
        if (dut.cnt_p !== 8'd0) begin fails++; $display("FAIL duty%0d_align got %0d want 0", duty, dut.cnt_p); end
        run_period(-1, duty, h, fl, lh);
        tests++;
        if (h != (SH ? 0 : int'(duty))) begin
            fails++; $display("FAIL duty%0d_first_period highs got %0d want %0d", duty, h, SH ? 0 : int'(duty));
        end
        run_period(-1, duty, h, fl, lh);
        tests++;
        if (h != int'(duty)) begin fails++; $display("FAIL duty%0d_highs got %0d want %0d", duty, h, duty); end
        tests++;
        if (fl != int'(duty)) begin fails++; $display("FAIL duty%0d_first_low got %0d want %0d", duty, fl, duty); end
        tests++;
        if (lh != 0) begin fails++; $display("FAIL duty%0d_late_high got %0d want 0", duty, lh); end
    endtask

    task automatic test_mid_change();
        int h, fl, lh;
        bus4.duty_cycle = 8'd100;
        do_reset();
        run_period(-1, 8'd100, h, fl, lh);
        run_period(50, 8'd20, h, fl, lh);
        tests++;
        if (h != (SH ? 100 : 50)) begin fails++; $display("FAIL change_cur_highs got %0d want %0d", h, SH ? 100 : 50); end
        tests++;
        if (fl != (SH ? 100 : 50)) begin fails++; $display("FAIL change_cur_first_low got %0d want %0d", fl, SH ? 100 : 50); end
        run_period(-1, 8'd20, h, fl, lh);
        tests++;
        if (h != 20) begin fails++; $display("FAIL change_next_highs got %0d want 20", h); end
        tests++;
        if (fl != 20 || lh != 0) begin fails++; $display("FAIL change_next_shape got first_low %0d late %0d want 20 0", fl, lh); end
    endtask

    task automatic test_reset_mid();
        int h, fl, lh;
        bus4.duty_cycle = 8'd200;
        do_reset();
        run_period(-1, 8'd200, h, fl, lh);
        repeat (130) @(negedge clk);
        tests++;
        if (dut.cnt_p !== 8'd130) begin fails++; $display("FAIL mid_pre_cnt_p got %0d want 130", dut.cnt_p); end
        tests++;
        if (dut.cnt_d !== 2'd1) begin fails++; $display("FAIL mid_pre_cnt_d got %0d want 1", dut.cnt_d); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (dut.cnt_p !== 8'd0) begin fails++; $display("FAIL mid_cnt_p got %0d want 0", dut.cnt_p); end
        tests++;
        if (dut.cnt_d !== 2'd3) begin fails++; $display("FAIL mid_cnt_d got %0d want 3", dut.cnt_d); end
        tests++;
        if (bus4.zero !== 1'b0) begin fails++; $display("FAIL mid_zero got %b want 0", bus4.zero); end
        tests++;
        if (bus4.pwm_out !== !SH) begin fails++; $display("FAIL mid_pwm got %b want %b", bus4.pwm_out, !SH); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            tests++;
            if (bus4.zero !== (k == 3)) begin fails++; $display("FAIL mid_tick_k%0d got %b want %b", k, bus4.zero, k == 3); end
        end
        tests++;
        if (dut.cnt_p !== 8'd4) begin fails++; $display("FAIL mid_post_cnt_p got %0d want 4", dut.cnt_p); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_tick();
        test_duty(8'd64);
        test_duty(8'd0);
        test_duty(8'd255);
        test_duty(8'd1);
        test_mid_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
